// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int          INST_BYTES   = 4;
    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;

    // Pointer width for a FIFO of the given depth; a single-entry FIFO still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; used as instruction queue and in-flight PC FIFO.
module sync_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy update; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count alone decides which entries are meaningful.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: credit-based request issue, in-order responses, redirect with cancellation.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              from_allowin,
    output logic              to_valid,
    output logic [ADDR_W-1:0] to_pc,
    output logic [DATA_W-1:0] to_inst
);
    localparam int OC_W = $clog2(MAX_OUTST + 1);
    localparam int QC_W = $clog2(DEPTH + 1);

    logic              reset_q;
    logic [ADDR_W-1:0] fetch_pc,      fetch_pc_next;
    logic              req_pend;
    logic [OC_W-1:0]   outst,         outst_next;
    logic [OC_W-1:0]   cancel,        cancel_next;
    logic              redirect_pend, redirect_pend_next;
    logic [ADDR_W-1:0] redirect_tgt,  redirect_tgt_next;

    logic              accept;
    logic              resp;
    logic              credit;
    logic              q_push, q_pop, q_full, q_empty;
    logic [QC_W-1:0]   q_count;
    logic [ADDR_W-1:0] resp_pc;
    logic              pc_full, pc_empty;
    logic [OC_W-1:0]   pc_count;

    // Credit rule: a request goes out only if its response is guaranteed a queue slot.
    assign credit    = (int'(outst) < MAX_OUTST) && (int'(outst) + int'(q_count) < DEPTH);
    assign inst_req  = req_pend | (~reset_q & credit);
    assign inst_addr = fetch_pc;
    assign accept    = inst_req & inst_addr_ok;
    assign resp      = inst_data_ok & (outst != '0);
    assign q_push    = resp & (cancel == '0) & ~br_taken;
    assign q_pop     = to_valid & from_allowin;
    assign to_valid  = ~q_empty;

    // Next-state for counters, fetch PC and deferred redirect.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        outst_next         = outst;
        fetch_pc_next      = fetch_pc;
        redirect_pend_next = redirect_pend;
        redirect_tgt_next  = redirect_tgt;

        if (accept && !resp)      outst_next = outst + OC_W'(1);
        else if (!accept && resp) outst_next = outst - OC_W'(1);

        cancel_next = cancel + OC_W'(accept & redirect_pend)
                             - OC_W'(resp && (cancel != '0));

        if (accept) begin
            fetch_pc_next      = redirect_pend ? redirect_tgt : fetch_pc + ADDR_W'(INST_BYTES);
            redirect_pend_next = 1'b0;
        end

        if (br_taken) begin
            // Everything still in flight after this cycle is on the wrong path.
            cancel_next = outst_next;
            if (inst_req && !inst_addr_ok) begin
                redirect_pend_next = 1'b1;
                redirect_tgt_next  = br_target;
            end else begin
                fetch_pc_next      = br_target;
                redirect_pend_next = 1'b0;
            end
        end
    end

    // State registers; reset_q keeps inst_req low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            reset_q       <= 1'b1;
            fetch_pc      <= RESET_PC;
            req_pend      <= 1'b0;
            outst         <= '0;
            cancel        <= '0;
            redirect_pend <= 1'b0;
            redirect_tgt  <= RESET_PC;
        end else begin
            reset_q       <= 1'b0;
            fetch_pc      <= fetch_pc_next;
            req_pend      <= inst_req & ~inst_addr_ok;
            outst         <= outst_next;
            cancel        <= cancel_next;
            redirect_pend <= redirect_pend_next;
            redirect_tgt  <= redirect_tgt_next;
        end
    end

    sync_fifo #(.W(ADDR_W), .DEPTH(MAX_OUTST)) u_pc_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (accept),
        .din   (inst_addr),
        .pop   (resp),
        .dout  (resp_pc),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count)
    );

    sync_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_inst_q (
        .clk   (clk),
        .reset (reset),
        .flush (br_taken),
        .push  (q_push),
        .din   ({resp_pc, inst_rdata}),
        .pop   (q_pop),
        .dout  ({to_pc, to_inst}),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    a_data_ok_outst: assert property (@(posedge clk) disable iff (reset)
        inst_data_ok |-> (outst != '0));
    a_pc_fifo_count: assert property (@(posedge clk) disable iff (reset)
        (pc_count == outst) && (pc_empty == (outst == '0)));
    a_pc_fifo_room:  assert property (@(posedge clk) disable iff (reset)
        accept |-> (!pc_full || resp));
    a_q_room:        assert property (@(posedge clk) disable iff (reset)
        q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order, one-cycle-latency memory model.
module tb_inst_fetch_queue;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        from_allowin = 1'b0;
    logic        to_valid;
    logic [31:0] to_pc;
    logic [31:0] to_inst;

    bit          mem_ready = 1'b0;
    bit          resp_en   = 1'b0;
    logic [31:0] mem_q [$];
    logic [31:0] acc_log [$];
    logic [31:0] pop_log [$];
    int          n_vec = 0;
    int          n_err = 0;

    inst_fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .from_allowin (from_allowin),
        .to_valid     (to_valid),
        .to_pc        (to_pc),
        .to_inst      (to_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 'x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory side, log handshakes at negedge, settle after posedge.
    task automatic tick();
        inst_addr_ok = mem_ready;
        if (resp_en && mem_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = word_of(mem_q[0]);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
        end
        @(negedge clk);
        if (!reset) begin
            if (inst_data_ok) mem_q.delete(0);
            if (inst_req && inst_addr_ok) begin
                mem_q.push_back(inst_addr);
                acc_log.push_back(inst_addr);
            end
            if (to_valid && from_allowin) begin
                pop_log.push_back(to_pc);
                check("inst_pairing", to_inst, word_of(to_pc));
            end
        end
        @(posedge clk);
        #1;
        br_taken = 1'b0;
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        reset = 1'b1;
        br_taken = 1'b0;
        mem_q.delete();
        acc_log.delete();
        pop_log.delete();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // 1: free-running fetch, one instruction per cycle
        mem_ready = 1; resp_en = 1; from_allowin = 1;
        do_reset();
        check("t1_req_first_cycle", inst_req, 1'b0);
        check("t1_valid_reset", to_valid, 1'b0);
        check("t1_addr_reset", inst_addr, RST_PC);
        tick();
        check("t1_first_req", inst_req, 1'b1);
        check("t1_first_addr", inst_addr, RST_PC);
        tick();
        check("t1_not_yet_valid", to_valid, 1'b0);
        tick();
        check("t1_latency_valid", to_valid, 1'b1);
        check("t1_first_pc", to_pc, RST_PC);
        repeat (6) tick();
        check("t1_pop_count", pop_log.size(), 6);
        check("t1_acc_count", acc_log.size(), 8);
        check("t1_acc0", at(acc_log, 0), 32'h1c00_0000);
        check("t1_acc1", at(acc_log, 1), 32'h1c00_0004);
        check("t1_acc2", at(acc_log, 2), 32'h1c00_0008);
        check("t1_pop1", at(pop_log, 1), 32'h1c00_0004);
        check("t1_pop5", at(pop_log, 5), 32'h1c00_0014);

        // 2: back-pressure fills the queue exactly
        from_allowin = 0;
        do_reset();
        repeat (8) tick();
        check("t2_full_valid", to_valid, 1'b1);
        check("t2_req_stopped", inst_req, 1'b0);
        check("t2_head_pc", to_pc, RST_PC);
        check("t2_acc_count", acc_log.size(), 4);
        repeat (3) tick();
        check("t2_head_stable", to_pc, RST_PC);
        check("t2_still_no_req", inst_req, 1'b0);
        from_allowin = 1;
        repeat (8) tick();
        check("t2_resume_addr", at(acc_log, 4), 32'h1c00_0010);
        check("t2_pop0", at(pop_log, 0), 32'h1c00_0000);
        check("t2_pop3", at(pop_log, 3), 32'h1c00_000c);
        check("t2_pop4", at(pop_log, 4), 32'h1c00_0010);

        // 3: redirect with two requests in flight
        resp_en = 0;
        do_reset();
        repeat (3) tick();
        check("t3_outst_limit", inst_req, 1'b0);
        check("t3_acc_count", acc_log.size(), 2);
        br_target = 32'h1c00_0100; br_taken = 1;
        tick();
        check("t3_new_fetch_pc", inst_addr, 32'h1c00_0100);
        check("t3_no_req_yet", inst_req, 1'b0);
        resp_en = 1;
        tick();
        check("t3_req_target", inst_req, 1'b1);
        check("t3_addr_target", inst_addr, 32'h1c00_0100);
        check("t3_drop1", to_valid, 1'b0);
        tick();
        check("t3_drop2", to_valid, 1'b0);
        tick();
        check("t3_valid_target", to_valid, 1'b1);
        check("t3_pc_target", to_pc, 32'h1c00_0100);
        check("t3_no_stale_pops", pop_log.size(), 0);

        // 4: redirect while a request is held; last target wins
        mem_ready = 0;
        do_reset();
        tick();
        check("t4_req_pending", inst_req, 1'b1);
        check("t4_addr_pending", inst_addr, RST_PC);
        tick();
        br_target = 32'h1c00_0180; br_taken = 1;
        tick();
        check("t4_addr_held", inst_addr, RST_PC);
        check("t4_req_held", inst_req, 1'b1);
        br_target = 32'h1c00_0200; br_taken = 1;
        tick();
        check("t4_addr_held2", inst_addr, RST_PC);
        mem_ready = 1;
        tick();
        check("t4_next_addr", inst_addr, 32'h1c00_0200);
        check("t4_next_req", inst_req, 1'b1);
        repeat (3) tick();
        check("t4_acc0", at(acc_log, 0), RST_PC);
        check("t4_acc1", at(acc_log, 1), 32'h1c00_0200);
        check("t4_first_pop", at(pop_log, 0), 32'h1c00_0200);

        // 5: redirect coincides with head pop and a returning word
        do_reset();
        repeat (4) tick();
        check("t5_head_before", to_pc, 32'h1c00_0004);
        br_target = 32'h1c00_0400; br_taken = 1;
        tick();
        check("t5_queue_empty", to_valid, 1'b0);
        check("t5_req_target", inst_req, 1'b1);
        check("t5_addr_target", inst_addr, 32'h1c00_0400);
        tick();
        tick();
        check("t5_valid_target", to_valid, 1'b1);
        check("t5_pc_target", to_pc, 32'h1c00_0400);
        tick();
        check("t5_pop_count", pop_log.size(), 3);
        check("t5_branch_popped", at(pop_log, 1), 32'h1c00_0004);
        check("t5_target_popped", at(pop_log, 2), 32'h1c00_0400);

        // 6: address wrap, then reset in the middle of traffic
        do_reset();
        br_target = 32'hffff_fffc; br_taken = 1;
        tick();
        check("t6_addr_top", inst_addr, 32'hffff_fffc);
        check("t6_req_top", inst_req, 1'b1);
        tick();
        check("t6_addr_wrap", inst_addr, 32'h0000_0000);
        repeat (3) tick();
        check("t6_pop_top", at(pop_log, 0), 32'hffff_fffc);
        check("t6_pop_wrap", at(pop_log, 1), 32'h0000_0000);
        reset = 1;
        mem_q.delete();
        tick();
        check("t6_rst_req", inst_req, 1'b0);
        check("t6_rst_valid", to_valid, 1'b0);
        check("t6_rst_addr", inst_addr, RST_PC);
        reset = 0;
        acc_log.delete();
        pop_log.delete();
        tick();
        check("t6_restart_req", inst_req, 1'b1);
        check("t6_restart_addr", inst_addr, RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
